control_interface_output: RTL and testbench

CONTROL_INTERFACE_OUTPUT -- requirements
Module: control_interface_output

---
 rtl/control_interface_output_if.sv | 27 ++
 rtl/control_interface_output.sv | 119 +++++++++++
 tb/tb_control_interface_output.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/control_interface_output_if.sv
// Bundle of the capture/exchange inputs and serial-output signals of
// control_interface_output; master drives captures and exchanges, slave is the serializer.
interface control_interface_output_if #(
  parameter int N_OUTPUT   = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                    sta;
  logic [N_OUTPUT*32-1:0]  data_in;
  logic                    exchange_data_sig;
  logic [31:0]             V_out;
  logic [ADDR_WIDTH-1:0]   addr_out;
  logic                    valid_out;
  logic                    busy;
  logic                    done_sig;
  logic                    overrun;
  logic                    fp_err;

  modport master (
    output sta, data_in, exchange_data_sig,
    input  V_out, addr_out, valid_out, busy, done_sig, overrun, fp_err
  );

  modport slave (
    input  sta, data_in, exchange_data_sig,
    output V_out, addr_out, valid_out, busy, done_sig, overrun, fp_err
  );
endinterface

// File: rtl/control_interface_output.sv
// Captures N_OUTPUT control-result words on sta and streams a snapshot of them word by
// word on exchange. Optional feature macro: CTRL_OUT_FP_SANITIZE_EN (zero Inf/NaN words).
module control_interface_output #(
  parameter int N_OUTPUT   = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  control_interface_output_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N_OUTPUT - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  start;
  logic [31:0]           cap_bank  [N_OUTPUT];
  logic [31:0]           send_bank [N_OUTPUT];
  logic [31:0]           word;
  logic [31:0]           emit;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.exchange_data_sig) begin
          state_nxt = SEND;
          cnt_nxt   = '0;
          start     = 1'b1;
        end
      end
      SEND: begin
        if (cnt == LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // send_bank copies the pre-edge capture contents, so a simultaneous sta lands only in cap_bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_OUTPUT; k++) begin
        cap_bank[k]  <= '0;
        send_bank[k] <= '0;
      end
    end else begin
      if (bus.sta) begin
        for (int unsigned k = 0; k < N_OUTPUT; k++)
          cap_bank[k] <= bus.data_in[32*k +: 32];
      end
      if (start) begin
        for (int unsigned k = 0; k < N_OUTPUT; k++)
          send_bank[k] <= cap_bank[k];
      end
    end
  end

  assign word = send_bank[cnt];

`ifdef CTRL_OUT_FP_SANITIZE_EN
  logic non_finite;
  assign non_finite = &word[30:23];
  assign emit       = non_finite ? '0 : word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus.fp_err <= 1'b0;
    else if (state == SEND && non_finite)
      bus.fp_err <= 1'b1;
  end
`else
  assign emit       = word;
  assign bus.fp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid_out <= 1'b0;
      bus.addr_out  <= '0;
      bus.V_out     <= '0;
      bus.busy      <= 1'b0;
      bus.done_sig  <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.valid_out <= (state == SEND);
      bus.addr_out  <= (state == SEND) ? cnt : '0;
      bus.V_out     <= (state == SEND) ? emit : '0;
      bus.busy      <= (state != IDLE);
      bus.done_sig  <= (state == DONE);
      if (bus.exchange_data_sig && state != IDLE)
        bus.overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_control_interface_output.sv
// Randomized and directed bench for control_interface_output against a timeline model:
// a transfer accepted at edge t shows word i after edge t+1+i and done after edge t+N+1.
module tb_control_interface_output;
  localparam int N  = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_interface_output_if #(.N_OUTPUT(N), .ADDR_WIDTH(AW)) bus ();

  control_interface_output #(.N_OUTPUT(N), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] words [N];
  logic [31:0] cap_m [N];
  logic [31:0] snap  [N];
  int          now;
  int          xfer_start;
  bit          ovr_m, fperr_m;
  bit          e_valid, e_busy, e_done;
  logic [31:0] e_word;
  logic [AW-1:0] e_addr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] emit_f(input logic [31:0] w);
`ifdef CTRL_OUT_FP_SANITIZE_EN
    return (w[30:23] == 8'hFF) ? 32'h0 : w;
`else
    return w;
`endif
  endfunction

  function automatic bit nonfinite_emitted(input logic [31:0] w);
`ifdef CTRL_OUT_FP_SANITIZE_EN
    return w[30:23] == 8'hFF;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      cap_m[k] = '0;
      snap[k]  = '0;
    end
    now = 0;
    xfer_start = -1000;
    ovr_m = 0; fperr_m = 0;
    e_valid = 0; e_busy = 0; e_done = 0; e_word = '0; e_addr = '0;
  endtask

  task automatic model_step();
    int d;
    now++;
    d = now - xfer_start;
    if (bus.exchange_data_sig) begin
      if (d >= N + 2) begin
        xfer_start = now;
        for (int k = 0; k < N; k++) snap[k] = cap_m[k];
      end else begin
        ovr_m = 1;
      end
    end
    if (bus.sta)
      for (int k = 0; k < N; k++) cap_m[k] = bus.data_in[32*k +: 32];
    d = now - xfer_start;
    e_valid = (d >= 1 && d <= N);
    e_addr  = e_valid ? AW'(d - 1) : '0;
    e_word  = e_valid ? emit_f(snap[d-1]) : '0;
    e_busy  = (d >= 1 && d <= N + 1);
    e_done  = (d == N + 1);
    if (e_valid && nonfinite_emitted(snap[d-1])) fperr_m = 1;
  endtask

  task automatic check_outputs();
    check_eq("valid_out", bus.valid_out, e_valid);
    check_eq("addr_out",  bus.addr_out,  e_addr);
    check_eq("V_out",     bus.V_out,     e_word);
    check_eq("busy",      bus.busy,      e_busy);
    check_eq("done_sig",  bus.done_sig,  e_done);
    check_eq("overrun",   bus.overrun,   ovr_m);
    check_eq("fp_err",    bus.fp_err,    fperr_m);
  endtask

  // Inputs are set at the falling edge; one rising edge is taken, then outputs checked.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1 check_outputs();
    bus.sta = 1'b0;
    bus.exchange_data_sig = 1'b0;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_words();
    for (int k = 0; k < N; k++) bus.data_in[32*k +: 32] = words[k];
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.sta = 1'b0;
    bus.exchange_data_sig = 1'b0;
    bus.data_in = '0;
    model_reset();
    @(negedge clk);
    check_outputs();
    tick();
    rst = 1'b0;

    // Exchange with no prior capture streams zeros
    bus.exchange_data_sig = 1'b1; tick();
    run(N + 3);

    // Basic capture then exchange two cycles later
    for (int k = 0; k < N; k++) words[k] = 32'h3F800000 + k;
    load_words(); bus.sta = 1'b1; tick();
    tick();
    bus.exchange_data_sig = 1'b1; tick();
    run(N + 3);

    // Simultaneous sta and exchange
    for (int k = 0; k < N; k++) words[k] = 32'h3F800000;
    load_words(); bus.sta = 1'b1; tick();
    for (int k = 0; k < N; k++) words[k] = 32'h40000000;
    load_words(); bus.sta = 1'b1; bus.exchange_data_sig = 1'b1; tick();
    run(N + 3);
    bus.exchange_data_sig = 1'b1; tick();
    run(N + 3);

    // Exchange and sta during an active transfer
    bus.exchange_data_sig = 1'b1; tick();
    run(2);
    for (int k = 0; k < N; k++) words[k] = 32'h12345678 ^ k;
    load_words(); bus.exchange_data_sig = 1'b1; bus.sta = 1'b1; tick();
    run(N + 3);
    bus.exchange_data_sig = 1'b1; tick();
    run(N + 3);

    // Reset mid-transfer, then immediate restart
    bus.exchange_data_sig = 1'b1; tick();
    run(5);
    async_reset();
    for (int k = 0; k < N; k++) words[k] = 32'hC0000000 + 16 * k;
    load_words(); bus.sta = 1'b1; tick();
    bus.exchange_data_sig = 1'b1; tick();
    run(N + 3);

    // Non-finite words
    for (int k = 0; k < N; k++) words[k] = 32'h3F000000 + k;
    words[2] = 32'h7FC00000;
    words[5] = 32'h7F800000;
    load_words(); bus.sta = 1'b1; tick();
    bus.exchange_data_sig = 1'b1; tick();
    run(N + 3);
    async_reset();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < N; k++) begin
          words[k] = $urandom;
          if ($urandom_range(0, 7) == 0) words[k][30:23] = 8'hFF;
        end
        load_words();
        bus.sta = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) bus.exchange_data_sig = 1'b1;
      if ($urandom_range(0, 299) == 0) async_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
